// File: rtl/prior_select_pkg.sv
// prior_select_pkg: state encoding and small helpers shared by the
// prior-select scan sequencer and its slot counter.
package prior_select_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic valToBool(input logic v);
        return (v == 1'b1);
    endfunction

    function automatic longint unsigned bitLimit(
        input longint unsigned v,
        input int unsigned     w
    );
        if (w >= 64) return v;
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < {32'd0, n}) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/prior_select_cnt.sv
// prior_select_cnt: enabled, clearable slot counter that saturates at the
// last slot and flags it.
module prior_select_cnt #(
    parameter int CAND_NUM  = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 srst_n_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [IDX_WIDTH-1:0] cnt_o,
    output logic                 is_last_o
);

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(CAND_NUM - 1);

    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == LAST);

endmodule

// File: rtl/prior_select_driver.sv
// prior_select_driver: scans CAND_NUM slots and captures the first flagged one.
// Define PRIOR_SELECT_EARLY_STOP_EN to end the scan on the first capture.
module prior_select_driver
    import prior_select_pkg::*;
#(
    parameter int              CAND_NUM  = 8,
    parameter int              IDX_WIDTH = 3,
    parameter int              WIDTH     = 8,
    parameter longint unsigned RST_VAL   = 0
) (
    input  logic                 clk,
    input  logic                 in_ctr_Srst_n,
    input  logic                 in_ctr_en,
    input  logic                 in_ctr_start,
    input  logic                 in_ctr_flag,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_ctr_init,
    output logic                 out_ctr_buf_en,
    output logic                 out_ctr_valid,
    output logic                 out_ctr_done,
    output logic                 out_busy,
    output logic                 out_fin,
    output logic                 out_found,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [WIDTH-1:0]     out_data
);

    localparam logic [WIDTH-1:0] RST_D = WIDTH'(bitLimit(RST_VAL, WIDTH));

    if ((clog2(CAND_NUM) > IDX_WIDTH) || (CAND_NUM < 2)) begin : g_bad_cfg
        $error("prior_select_driver: CAND_NUM does not fit IDX_WIDTH");
    end

    state_e               state_q, state_d;
    logic                 found_q, found_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 fin_q, fin_d;

    logic                 en, start, flag;
    logic                 in_scan, capture, scan_end;
    logic [IDX_WIDTH-1:0] cnt;
    logic                 is_last;

    assign en      = valToBool(in_ctr_en);
    assign start   = valToBool(in_ctr_start);
    assign flag    = valToBool(in_ctr_flag);
    assign in_scan = (state_q == SCAN);
    assign capture = en && in_scan && flag && !found_q;

`ifdef PRIOR_SELECT_EARLY_STOP_EN
    assign scan_end = is_last || capture;
`else
    assign scan_end = is_last;
`endif

    prior_select_cnt #(
        .CAND_NUM  (CAND_NUM),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_cnt (
        .clk       (clk),
        .srst_n_i  (in_ctr_Srst_n),
        .en_i      (en),
        .clr_i     ((state_q == INIT) || (in_scan && scan_end)),
        .inc_i     (in_scan),
        .cnt_o     (cnt),
        .is_last_o (is_last)
    );

    always_ff @(posedge clk) begin
        if (!in_ctr_Srst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                IDLE:    if (start) state_d = INIT;
                INIT:    state_d = SCAN;
                SCAN:    if (scan_end) state_d = DONE;
                DONE:    if (start) state_d = INIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_ctr_init   = en && (state_q == INIT);
        out_ctr_buf_en = en && in_scan;
        out_ctr_valid  = flag && out_ctr_buf_en;
        out_ctr_done   = out_ctr_buf_en && scan_end;
        out_busy       = (state_q == INIT) || in_scan;
    end

    // Results are cleared in INIT so a restart from DONE starts clean.
    always_comb begin
        found_d = found_q;
        idx_d   = idx_q;
        data_d  = data_q;
        fin_d   = 1'b0;
        if (en) begin
            if (state_q == INIT) begin
                found_d = 1'b0;
                idx_d   = '0;
                data_d  = RST_D;
            end else if (capture) begin
                found_d = 1'b1;
                idx_d   = cnt;
                data_d  = in_data;
            end
            fin_d = in_scan && scan_end;
        end
    end

    always_ff @(posedge clk) begin
        if (!in_ctr_Srst_n) begin
            found_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= RST_D;
            fin_q   <= 1'b0;
        end else begin
            found_q <= found_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            fin_q   <= fin_d;
        end
    end

    assign out_fin   = fin_q;
    assign out_found = found_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;

endmodule
